stopwatch_controller: RTL and testbench

Control FSM that sequences the four-digit BCD mm:ss stopwatch counter chain. It turns debounced front-panel buttons and the 1 Hz tick into the counter's enable, direction and load controls, and detects terminal count in both directions. It raises a timed alarm at terminal count. It sits between the button debouncers and one-second clock on one side and the counter datapath on the other, and reads the counter's current value back for terminal detection.

---
 rtl/stopwatch_controller.sv | 180 ++++++++++++++++++
 tb/tb_stopwatch_controller.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_controller.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_controller
// Description : Control FSM for a four-digit BCD mm:ss stopwatch counter
//               chain. Turns debounced buttons and the 1 Hz tick into the
//               counter enable / direction / load controls, detects terminal
//               count in both directions and raises a timed alarm.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_controller #(
    parameter int NUMBER_OF_DIGITS         = 4,
    parameter int NUMBER_OF_BITS_PER_DIGIT = 4,
    parameter int ALARM_SECONDS            = 5,
    parameter logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] MAX_COUNT = 16'h5959
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                tick,
    input  logic                                                btn_start_stop,
    input  logic                                                btn_clear,
    input  logic                                                btn_mode,
    input  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] preset,
    input  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] count,
    output logic                                                count_enable,
    output logic                                                up_down,
    output logic                                                load,
    output logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] load_value,
    output logic                                                running,
    output logic                                                alarm,
    output logic [1:0]                                          state
);

    localparam int         c_WIDTH       = NUMBER_OF_DIGITS * NUMBER_OF_BITS_PER_DIGIT;
    localparam logic [3:0] c_ALARM_START = 4'(ALARM_SECONDS);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_RUNNING = 2'd1;
    localparam logic [1:0] c_PAUSED  = 2'd2;
    localparam logic [1:0] c_EXPIRED = 2'd3;

    // Registered state
    logic [1:0]         r_state;
    logic               r_up_down;
    logic               r_load;
    logic [c_WIDTH-1:0] r_load_value;
    logic               r_alarm;
    logic [3:0]         r_alarm_cnt;
    logic               r_clear_q;
    logic               r_start_stop_q;
    logic               r_mode_q;

    // Next-state values
    logic [1:0]         w_next_state;
    logic               w_next_up_down;
    logic               w_next_load;
    logic [c_WIDTH-1:0] w_next_load_value;
    logic               w_next_alarm;
    logic [3:0]         w_next_alarm_cnt;

    // Press detection; only the highest-priority press acts in a cycle
    logic               w_press_clear;
    logic               w_press_start_stop;
    logic               w_press_mode;
    logic [c_WIDTH-1:0] w_term;
    logic               w_at_term;

    assign w_press_clear      = btn_clear & ~r_clear_q;
    assign w_press_start_stop = btn_start_stop & ~r_start_stop_q & ~w_press_clear;
    assign w_press_mode       = btn_mode & ~r_mode_q & ~w_press_clear & ~(btn_start_stop & ~r_start_stop_q);

    // Terminal value depends on direction: 59:59 counting up, 00:00 counting down
    assign w_term    = r_up_down ? MAX_COUNT : '0;
    assign w_at_term = (count == w_term);

    // Enable never pushes the counter past terminal and is suppressed by a clear
    assign count_enable = tick & (r_state == c_RUNNING) & ~w_at_term & ~w_press_clear;

    assign up_down    = r_up_down;
    assign load       = r_load;
    assign load_value = r_load_value;
    assign running    = (r_state == c_RUNNING);
    assign alarm      = r_alarm;
    assign state      = r_state;

    // Button history; held at 1 through reset so a held button gives no press
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_clear_q      <= 1'b1;
            r_start_stop_q <= 1'b1;
            r_mode_q       <= 1'b1;
        end else begin
            r_clear_q      <= btn_clear;
            r_start_stop_q <= btn_start_stop;
            r_mode_q       <= btn_mode;
        end
    end

    // State, direction, load and alarm registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= c_IDLE;
            r_up_down    <= 1'b1;
            r_load       <= 1'b0;
            r_load_value <= '0;
            r_alarm      <= 1'b0;
            r_alarm_cnt  <= 4'd0;
        end else begin
            r_state      <= w_next_state;
            r_up_down    <= w_next_up_down;
            r_load       <= w_next_load;
            r_load_value <= w_next_load_value;
            r_alarm      <= w_next_alarm;
            r_alarm_cnt  <= w_next_alarm_cnt;
        end
    end

    // Next-state logic; clear overrides everything else from any state
    always_comb begin
        w_next_state      = r_state;
        w_next_up_down    = r_up_down;
        w_next_load       = 1'b0;
        w_next_load_value = r_load_value;
        w_next_alarm      = r_alarm;
        w_next_alarm_cnt  = r_alarm_cnt;

        if (w_press_clear) begin
            w_next_state      = c_IDLE;
            w_next_alarm      = 1'b0;
            w_next_alarm_cnt  = 4'd0;
            w_next_load       = 1'b1;
            w_next_load_value = r_up_down ? '0 : preset;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_press_start_stop) begin
                        // Counting down from 00:00 would expire instantly; ignore it
                        if (r_up_down || (count != '0)) begin
                            w_next_state = c_RUNNING;
                        end
                    end else if (w_press_mode) begin
                        // New direction is ~r_up_down: up loads zero, down loads preset
                        w_next_up_down    = ~r_up_down;
                        w_next_load       = 1'b1;
                        w_next_load_value = r_up_down ? preset : '0;
                    end
                end
                c_RUNNING: begin
                    if (w_press_start_stop) begin
                        w_next_state = c_PAUSED;
                    end else if (tick && w_at_term) begin
                        w_next_state     = c_EXPIRED;
                        w_next_alarm     = 1'b1;
                        w_next_alarm_cnt = c_ALARM_START;
                    end
                end
                c_PAUSED: begin
                    if (w_press_start_stop) begin
                        w_next_state = c_RUNNING;
                    end
                end
                c_EXPIRED: begin
                    if (tick && (r_alarm_cnt != 4'd0)) begin
                        w_next_alarm_cnt = r_alarm_cnt - 4'd1;
                        if (r_alarm_cnt == 4'd1) begin
                            w_next_alarm = 1'b0;
                        end
                    end
                    if (w_press_start_stop) begin
                        w_next_alarm = 1'b0;
                    end
                end
                default: begin
                    w_next_state = c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_controller
// Description : Self-checking bench for stopwatch_controller. Expected output
//               values are queued as stimulus is applied and compared at the
//               falling edge of the cycle they refer to.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_controller;

    localparam int c_WIDTH = 16;

    localparam int c_SIG_CE    = 0;
    localparam int c_SIG_UD    = 1;
    localparam int c_SIG_LOAD  = 2;
    localparam int c_SIG_LVAL  = 3;
    localparam int c_SIG_RUN   = 4;
    localparam int c_SIG_ALARM = 5;
    localparam int c_SIG_STATE = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               tick;
    logic               btn_start_stop;
    logic               btn_clear;
    logic               btn_mode;
    logic [c_WIDTH-1:0] preset;
    logic [c_WIDTH-1:0] count;
    logic               count_enable;
    logic               up_down;
    logic               load;
    logic [c_WIDTH-1:0] load_value;
    logic               running;
    logic               alarm;
    logic [1:0]         state;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    stopwatch_controller #(
        .NUMBER_OF_DIGITS         (4),
        .NUMBER_OF_BITS_PER_DIGIT (4),
        .ALARM_SECONDS            (5),
        .MAX_COUNT                (16'h5959)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .tick           (tick),
        .btn_start_stop (btn_start_stop),
        .btn_clear      (btn_clear),
        .btn_mode       (btn_mode),
        .preset         (preset),
        .count          (count),
        .count_enable   (count_enable),
        .up_down        (up_down),
        .load           (load),
        .load_value     (load_value),
        .running        (running),
        .alarm          (alarm),
        .state          (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", tag, got, exp);
        end
    endtask

    task automatic expect_sig(input string tag, input int sig, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] sig_value(input int sig);
        case (sig)
            c_SIG_CE:    return {31'd0, count_enable};
            c_SIG_UD:    return {31'd0, up_down};
            c_SIG_LOAD:  return {31'd0, load};
            c_SIG_LVAL:  return {16'd0, load_value};
            c_SIG_RUN:   return {31'd0, running};
            c_SIG_ALARM: return {31'd0, alarm};
            default:     return {30'd0, state};
        endcase
    endfunction

    // Compare queued expectations at negedge, then advance past the next posedge
    task automatic run_cycle();
        exp_t e;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val(e.tag, sig_value(e.sig), e.val);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic press_start();
        btn_start_stop = 1'b1;
        run_cycle();
        btn_start_stop = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        tick           = 1'b0;
        btn_start_stop = 1'b1;
        btn_clear      = 1'b0;
        btn_mode       = 1'b0;
        preset         = 16'h0000;
        count          = 16'h0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;

        // Reset state, start button still held from reset
        expect_sig("rst_state", c_SIG_STATE, 0);
        expect_sig("rst_updown", c_SIG_UD, 1);
        expect_sig("rst_alarm", c_SIG_ALARM, 0);
        expect_sig("rst_load", c_SIG_LOAD, 0);
        expect_sig("rst_lval", c_SIG_LVAL, 0);
        expect_sig("rst_running", c_SIG_RUN, 0);
        run_cycle();
        expect_sig("hold_state", c_SIG_STATE, 0);
        run_cycle();
        btn_start_stop = 1'b0;
        run_cycle();
        press_start();
        expect_sig("start_state", c_SIG_STATE, 1);
        expect_sig("start_running", c_SIG_RUN, 1);
        run_cycle();

        // Up mode: three ticks, each enabled, with idle cycles between
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            expect_sig($sformatf("up_ce_tick%0d", i), c_SIG_CE, 1);
            run_cycle();
            tick  = 1'b0;
            count = count + 16'd1;
            expect_sig($sformatf("up_ce_idle%0d", i), c_SIG_CE, 0);
            run_cycle();
        end

        // Pause coinciding with a tick still counts that tick
        tick = 1'b1;
        btn_start_stop = 1'b1;
        expect_sig("pause_tick_ce", c_SIG_CE, 1);
        run_cycle();
        tick = 1'b0;
        btn_start_stop = 1'b0;
        count = count + 16'd1;
        expect_sig("paused_state", c_SIG_STATE, 2);
        run_cycle();
        tick = 1'b1;
        expect_sig("paused_ce", c_SIG_CE, 0);
        run_cycle();
        tick = 1'b0;

        // Mode ignored in PAUSED
        preset = 16'h0130;
        btn_mode = 1'b1;
        run_cycle();
        btn_mode = 1'b0;
        expect_sig("paused_mode_ud", c_SIG_UD, 1);
        expect_sig("paused_mode_load", c_SIG_LOAD, 0);
        expect_sig("paused_mode_state", c_SIG_STATE, 2);
        run_cycle();

        // Resume, then reach 59:59 and expire
        press_start();
        expect_sig("resume_state", c_SIG_STATE, 1);
        run_cycle();
        count = 16'h5959;
        tick = 1'b1;
        expect_sig("term_up_ce", c_SIG_CE, 0);
        run_cycle();
        tick = 1'b0;
        expect_sig("expired_state", c_SIG_STATE, 3);
        expect_sig("expired_alarm", c_SIG_ALARM, 1);
        expect_sig("expired_running", c_SIG_RUN, 0);
        run_cycle();
        for (int i = 0; i < 5; i++) begin
            expect_sig($sformatf("alarm_on%0d", i), c_SIG_ALARM, 1);
            tick = 1'b1;
            run_cycle();
            tick = 1'b0;
            run_cycle();
        end
        expect_sig("alarm_off", c_SIG_ALARM, 0);
        expect_sig("alarm_off_state", c_SIG_STATE, 3);
        run_cycle();

        // Clear from EXPIRED in up mode loads zero
        btn_clear = 1'b1;
        run_cycle();
        btn_clear = 1'b0;
        expect_sig("clr_up_state", c_SIG_STATE, 0);
        expect_sig("clr_up_load", c_SIG_LOAD, 1);
        expect_sig("clr_up_lval", c_SIG_LVAL, 16'h0000);
        run_cycle();
        expect_sig("clr_up_load_end", c_SIG_LOAD, 0);
        run_cycle();

        // Mode press in IDLE switches to down and loads preset
        count = 16'h0000;
        btn_mode = 1'b1;
        run_cycle();
        btn_mode = 1'b0;
        expect_sig("mode_ud", c_SIG_UD, 0);
        expect_sig("mode_load", c_SIG_LOAD, 1);
        expect_sig("mode_lval", c_SIG_LVAL, 16'h0130);
        run_cycle();
        expect_sig("mode_load_end", c_SIG_LOAD, 0);
        expect_sig("mode_lval_hold", c_SIG_LVAL, 16'h0130);
        run_cycle();

        // Down mode from 00:00: start ignored
        press_start();
        expect_sig("down_zero_state", c_SIG_STATE, 0);
        run_cycle();

        // Down run from 00:02; start with tick gives no enable
        count = 16'h0002;
        tick = 1'b1;
        btn_start_stop = 1'b1;
        expect_sig("start_tick_ce", c_SIG_CE, 0);
        run_cycle();
        tick = 1'b0;
        btn_start_stop = 1'b0;
        expect_sig("down_run_state", c_SIG_STATE, 1);
        run_cycle();
        for (int i = 0; i < 2; i++) begin
            tick = 1'b1;
            expect_sig($sformatf("down_ce%0d", i), c_SIG_CE, 1);
            run_cycle();
            tick = 1'b0;
            count = count - 16'd1;
            run_cycle();
        end
        tick = 1'b1;
        expect_sig("term_down_ce", c_SIG_CE, 0);
        run_cycle();
        tick = 1'b0;
        expect_sig("down_exp_state", c_SIG_STATE, 3);
        expect_sig("down_exp_alarm", c_SIG_ALARM, 1);
        run_cycle();
        tick = 1'b1;
        run_cycle();
        tick = 1'b0;
        expect_sig("mid_alarm", c_SIG_ALARM, 1);
        run_cycle();
        press_start();
        expect_sig("ack_alarm", c_SIG_ALARM, 0);
        expect_sig("ack_state", c_SIG_STATE, 3);
        run_cycle();
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1;
            run_cycle();
            tick = 1'b0;
            run_cycle();
        end
        expect_sig("ack_alarm_stays", c_SIG_ALARM, 0);
        run_cycle();

        // Clear to IDLE in down mode loads the new preset
        preset = 16'h0010;
        btn_clear = 1'b1;
        run_cycle();
        btn_clear = 1'b0;
        expect_sig("clr_dn_lval", c_SIG_LVAL, 16'h0010);
        expect_sig("clr_dn_ud", c_SIG_UD, 0);
        run_cycle();

        // Clear together with tick while RUNNING
        count = 16'h0010;
        press_start();
        expect_sig("run2_state", c_SIG_STATE, 1);
        run_cycle();
        tick = 1'b1;
        btn_clear = 1'b1;
        expect_sig("clr_tick_ce", c_SIG_CE, 0);
        run_cycle();
        tick = 1'b0;
        btn_clear = 1'b0;
        expect_sig("clr_tick_state", c_SIG_STATE, 0);
        expect_sig("clr_tick_load", c_SIG_LOAD, 1);
        expect_sig("clr_tick_lval", c_SIG_LVAL, 16'h0010);
        expect_sig("clr_tick_ud", c_SIG_UD, 0);
        run_cycle();
        expect_sig("clr_tick_load_end", c_SIG_LOAD, 0);
        run_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
